// File: rtl/lc3_pkg.sv
// Shared LC-3 register-file definitions: widths, register count and the access-controller state type.
package lc3_pkg;

    localparam int unsigned REG_W        = 16;
    localparam int unsigned REG_ADDR_W   = 3;
    localparam int unsigned NUM_REGS     = 8;
    localparam int unsigned STARVE_LIMIT = 15;

    typedef enum logic {
        RFC_IDLE,
        RFC_CLEAR
    } rfc_state_t;

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Debug/host access port of the register-file controller: request/grant plus read-return.
interface regfile_access_ctrl_if
    import lc3_pkg::*;
#(
    parameter int unsigned DATA_W = REG_W,
    parameter int unsigned ADDR_W = REG_ADDR_W
) ();

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    modport master (
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata
    );

    modport slave (
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata
    );

endinterface

// File: rtl/rfc_starve_counter.sv
// Debug starvation counter: counts denied debug cycles and flags when a forced grant is due.
// Only built with REGFILE_DBG_FAIRNESS_EN.
`ifdef REGFILE_DBG_FAIRNESS_EN
module rfc_starve_counter
    import lc3_pkg::*;
#(
    parameter int unsigned LIMIT = STARVE_LIMIT
) (
    input  logic Clk,
    input  logic Reset,
    input  logic wait_cycle,
    input  logic clr,
    output logic starved
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt;

    // Saturates at LIMIT so a held request stays flagged until it is served.
    always_ff @(posedge Clk) begin
        if (Reset || clr) begin
            cnt <= '0;
        end else if (wait_cycle && (cnt != CNT_W'(LIMIT))) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign starved = (cnt == CNT_W'(LIMIT));

endmodule
`endif

// File: rtl/regfile_access_ctrl.sv
// Shares the LC-3 register file between the CPU and a debug port and runs the R0..R7 clear sequence.
// Optional debug fairness (forced grant after starvation) enabled by REGFILE_DBG_FAIRNESS_EN.
module regfile_access_ctrl
    import lc3_pkg::*;
#(
    parameter int unsigned DATA_W = REG_W,
    parameter int unsigned NREGS  = NUM_REGS,
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_ld,
    input  logic [ADDR_W-1:0] cpu_dr,
    input  logic [DATA_W-1:0] cpu_din,
    input  logic [ADDR_W-1:0] cpu_sr1,
    input  logic              cpu_sr_use,
    regfile_access_ctrl_if.slave dbg,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              cpu_stall,
    output logic              rf_load,
    output logic [ADDR_W-1:0] rf_dr,
    output logic [DATA_W-1:0] rf_din,
    output logic [ADDR_W-1:0] rf_sr1,
    input  logic [DATA_W-1:0] rf_sr1_data
);

    rfc_state_t        state, state_next;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_next;
    logic              gnt;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic              force_gnt;

`ifdef REGFILE_DBG_FAIRNESS_EN
    logic starved;

    rfc_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
        .Clk        (Clk),
        .Reset      (Reset),
        .wait_cycle ((state == RFC_IDLE) && dbg.dbg_req && !gnt),
        .clr        (gnt || !dbg.dbg_req),
        .starved    (starved)
    );

    assign force_gnt = starved && (state == RFC_IDLE) && dbg.dbg_req && !clr_start;
`else
    assign force_gnt = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= RFC_IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    // Write-port / SR1 steering: CLEAR beats CPU, CPU beats debug.
    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        gnt          = 1'b0;
        clr_busy     = 1'b0;
        cpu_stall    = 1'b0;
        rf_load      = cpu_ld;
        rf_dr        = cpu_dr;
        rf_din       = cpu_din;
        rf_sr1       = cpu_sr1;

        case (state)
            RFC_IDLE: begin
                if (clr_start) begin
                    state_next = RFC_CLEAR;
                    rf_load    = 1'b0;
                end else begin
                    gnt = dbg.dbg_req && !cpu_ld && (dbg.dbg_we || !cpu_sr_use);
                    if (force_gnt) begin
                        gnt       = 1'b1;
                        cpu_stall = 1'b1;
                    end
                    if (gnt) begin
                        if (dbg.dbg_we) begin
                            rf_load = 1'b1;
                            rf_dr   = dbg.dbg_addr;
                            rf_din  = dbg.dbg_wdata;
                        end else begin
                            rf_load = 1'b0;
                            rf_sr1  = dbg.dbg_addr;
                        end
                    end
                end
            end
            RFC_CLEAR: begin
                clr_busy     = 1'b1;
                cpu_stall    = 1'b1;
                rf_load      = 1'b1;
                rf_dr        = clr_cnt;
                rf_din       = '0;
                clr_cnt_next = clr_cnt + ADDR_W'(1);
                if (clr_cnt == ADDR_W'(NREGS - 1)) begin
                    state_next   = RFC_IDLE;
                    clr_cnt_next = '0;
                end
            end
            default: state_next = RFC_IDLE;
        endcase
    end

    // Debug read return: capture at the grant edge, pulse valid the following cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= gnt && !dbg.dbg_we;
            if (gnt && !dbg.dbg_we) begin
                rdata_q <= rf_sr1_data;
            end
        end
    end

    assign dbg.dbg_gnt    = gnt;
    assign dbg.dbg_rvalid = rvalid_q;
    assign dbg.dbg_rdata  = rdata_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Self-checking bench for regfile_access_ctrl: vector table for IDLE arbitration plus clear/reset/starvation sequences.
module tb_regfile_access_ctrl;

    logic        Clk;
    logic        Reset;
    logic        cpu_ld;
    logic [2:0]  cpu_dr;
    logic [15:0] cpu_din;
    logic [2:0]  cpu_sr1;
    logic        cpu_sr_use;
    logic        clr_start;
    logic        clr_busy;
    logic        cpu_stall;
    logic        rf_load;
    logic [2:0]  rf_dr;
    logic [15:0] rf_din;
    logic [2:0]  rf_sr1;
    logic [15:0] rf_sr1_data;

    regfile_access_ctrl_if dbg_if ();

    regfile_access_ctrl dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .cpu_ld      (cpu_ld),
        .cpu_dr      (cpu_dr),
        .cpu_din     (cpu_din),
        .cpu_sr1     (cpu_sr1),
        .cpu_sr_use  (cpu_sr_use),
        .dbg         (dbg_if),
        .clr_start   (clr_start),
        .clr_busy    (clr_busy),
        .cpu_stall   (cpu_stall),
        .rf_load     (rf_load),
        .rf_dr       (rf_dr),
        .rf_din      (rf_din),
        .rf_sr1      (rf_sr1),
        .rf_sr1_data (rf_sr1_data)
    );

    // Register-file model the controller drives.
    logic [15:0] rf_mem [8];
    always @(posedge Clk) if (rf_load) rf_mem[rf_dr] <= rf_din;
    assign rf_sr1_data = rf_mem[rf_sr1];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] sb_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard side: every rvalid pulse must match the oldest predicted read.
    always @(negedge Clk) begin
        if (!Reset && dbg_if.dbg_rvalid) begin
            if (sb_q.size() == 0) chk("rvalid_unexpected", 32'(dbg_if.dbg_rvalid), 32'd0);
            else chk("dbg_rdata", 32'(dbg_if.dbg_rdata), 32'(sb_q.pop_front()));
        end
    end

    typedef struct {
        logic        ld;
        logic [2:0]  dr;
        logic [15:0] din;
        logic [2:0]  sr1;
        logic        sr_use;
        logic        req;
        logic        we;
        logic [2:0]  addr;
        logic [15:0] wdata;
        logic        e_gnt;
        logic        e_load;
        logic [2:0]  e_dr;
        logic [15:0] e_din;
        logic [2:0]  e_sr1;
        logic [15:0] e_rdata;
    } vec_t;

    vec_t vt [9];

    task automatic idle_inputs();
        cpu_ld = 0; cpu_dr = 0; cpu_din = 0; cpu_sr1 = 0; cpu_sr_use = 0; clr_start = 0;
        dbg_if.dbg_req = 0; dbg_if.dbg_we = 0; dbg_if.dbg_addr = 0; dbg_if.dbg_wdata = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) rf_mem[i] = 16'hA000 + 16'(i);
        // {ld,dr,din,sr1,use, req,we,addr,wdata, e_gnt,e_load,e_dr,e_din,e_sr1,e_rdata}
        vt[0] = '{1'b1, 3'd3, 16'h1234, 3'd1, 1'b0, 1'b1, 1'b1, 3'd6, 16'h5555, 1'b0, 1'b1, 3'd3, 16'h1234, 3'd1, 16'h0};
        vt[1] = '{1'b0, 3'd3, 16'h1234, 3'd1, 1'b0, 1'b1, 1'b1, 3'd6, 16'h5555, 1'b1, 1'b1, 3'd6, 16'h5555, 3'd1, 16'h0};
        vt[2] = '{1'b0, 3'd0, 16'h0000, 3'd2, 1'b1, 1'b1, 1'b1, 3'd5, 16'hBEEF, 1'b1, 1'b1, 3'd5, 16'hBEEF, 3'd2, 16'h0};
        vt[3] = '{1'b0, 3'd0, 16'h0000, 3'd2, 1'b0, 1'b1, 1'b0, 3'd5, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h0000, 3'd5, 16'hBEEF};
        vt[4] = '{1'b0, 3'd0, 16'h0000, 3'd4, 1'b1, 1'b1, 1'b0, 3'd3, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd4, 16'h0};
        vt[5] = '{1'b0, 3'd0, 16'h0000, 3'd4, 1'b0, 1'b1, 1'b0, 3'd3, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h0000, 3'd3, 16'h1234};
        vt[6] = '{1'b0, 3'd0, 16'h0000, 3'd4, 1'b0, 1'b1, 1'b0, 3'd6, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h0000, 3'd6, 16'h5555};
        vt[7] = '{1'b1, 3'd7, 16'h0707, 3'd7, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd7, 16'h0707, 3'd7, 16'h0};
        vt[8] = '{1'b1, 3'd4, 16'h4444, 3'd0, 1'b0, 1'b1, 1'b0, 3'd5, 16'h0000, 1'b0, 1'b1, 3'd4, 16'h4444, 3'd0, 16'h0};

        Reset = 1;
        idle_inputs();
        repeat (2) @(negedge Clk);
        Reset = 0;
        #1;
        chk("rst_clr_busy", 32'(clr_busy), 32'd0);
        chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        chk("rst_rvalid", 32'(dbg_if.dbg_rvalid), 32'd0);
        chk("rst_rdata", 32'(dbg_if.dbg_rdata), 32'd0);

        // Clear entry: clr_start wins over a CPU write and a debug request, no write that cycle.
        @(negedge Clk);
        clr_start = 1; cpu_ld = 1; cpu_dr = 3'd2; cpu_din = 16'hFFFF;
        dbg_if.dbg_req = 1; dbg_if.dbg_we = 1; dbg_if.dbg_addr = 3'd1; dbg_if.dbg_wdata = 16'h1111;
        #1;
        chk("clr_entry_load", 32'(rf_load), 32'd0);
        chk("clr_entry_gnt", 32'(dbg_if.dbg_gnt), 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            clr_start = (k == 3);
            #1;
            chk("clr_busy", 32'(clr_busy), 32'd1);
            chk("clr_stall", 32'(cpu_stall), 32'd1);
            chk("clr_gnt", 32'(dbg_if.dbg_gnt), 32'd0);
            chk("clr_dr_din", {12'd0, rf_load, rf_dr, rf_din}, {12'd0, 1'b1, 3'(k), 16'h0});
        end
        @(negedge Clk);
        idle_inputs();
        #1;
        chk("clr_done_busy", 32'(clr_busy), 32'd0);
        chk("clr_done_stall", 32'(cpu_stall), 32'd0);
        for (int i = 0; i < 8; i++) chk("clr_reg_zero", 32'(rf_mem[i]), 32'd0);

        // IDLE arbitration vectors.
        for (int v = 0; v < 9; v++) begin
            @(negedge Clk);
            cpu_ld = vt[v].ld; cpu_dr = vt[v].dr; cpu_din = vt[v].din;
            cpu_sr1 = vt[v].sr1; cpu_sr_use = vt[v].sr_use;
            dbg_if.dbg_req = vt[v].req; dbg_if.dbg_we = vt[v].we;
            dbg_if.dbg_addr = vt[v].addr; dbg_if.dbg_wdata = vt[v].wdata;
            if (vt[v].e_gnt && !vt[v].we) sb_q.push_back(vt[v].e_rdata);
            #1;
            chk($sformatf("vec%0d_gnt", v), 32'(dbg_if.dbg_gnt), 32'(vt[v].e_gnt));
            chk($sformatf("vec%0d_load", v), 32'(rf_load), 32'(vt[v].e_load));
            chk($sformatf("vec%0d_sr1", v), 32'(rf_sr1), 32'(vt[v].e_sr1));
            if (vt[v].e_load) chk($sformatf("vec%0d_wr", v), {13'd0, rf_dr, rf_din}, {13'd0, vt[v].e_dr, vt[v].e_din});
        end
        @(negedge Clk);
        idle_inputs();
        #1;
        chk("cpu_wr_r3", 32'(rf_mem[3]), 32'h1234);

        // Debug read blocked by cpu_sr_use for 4 cycles, granted when it drops.
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk);
            cpu_sr1 = 3'd1; cpu_sr_use = (c < 4);
            dbg_if.dbg_req = 1; dbg_if.dbg_we = 0; dbg_if.dbg_addr = 3'd5;
            if (c == 4) sb_q.push_back(16'hBEEF);
            #1;
            chk("sruse_gnt", 32'(dbg_if.dbg_gnt), 32'(c == 4));
            chk("sruse_sr1", 32'(rf_sr1), (c < 4) ? 32'd1 : 32'd5);
        end

        // Read just before clear, then Reset at clear counter 4.
        @(negedge Clk);
        idle_inputs();
        dbg_if.dbg_req = 1; dbg_if.dbg_addr = 3'd6;
        sb_q.push_back(16'h5555);
        #1;
        chk("preclr_gnt", 32'(dbg_if.dbg_gnt), 32'd1);
        @(negedge Clk);
        idle_inputs();
        clr_start = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            clr_start = 0;
            #1;
            chk("abort_dr", 32'(rf_dr), 32'(k));
        end
        Reset = 1;
        @(negedge Clk);
        Reset = 0;
        #1;
        chk("abort_busy", 32'(clr_busy), 32'd0);
        chk("abort_stall", 32'(cpu_stall), 32'd0);
        chk("abort_rdata_rst", 32'(dbg_if.dbg_rdata), 32'd0);
        for (int i = 0; i < 4; i++) chk("abort_low_zero", 32'(rf_mem[i]), 32'd0);
        chk("abort_r5", 32'(rf_mem[5]), 32'hBEEF);
        chk("abort_r6", 32'(rf_mem[6]), 32'h5555);
        chk("abort_r7", 32'(rf_mem[7]), 32'h0707);
        @(negedge Clk);
        #1;
        chk("abort_idle_busy", 32'(clr_busy), 32'd0);

        // Pending read while the CPU keeps SR1 busy and writes.
        @(negedge Clk);
        cpu_ld = 1; cpu_dr = 3'd0; cpu_din = 16'h0; cpu_sr1 = 3'd2; cpu_sr_use = 1;
        dbg_if.dbg_req = 1; dbg_if.dbg_we = 0; dbg_if.dbg_addr = 3'd7;
`ifdef REGFILE_DBG_FAIRNESS_EN
        for (int c = 1; c <= 16; c++) begin
            if (c > 1) @(negedge Clk);
            if (c == 16) sb_q.push_back(16'h0707);
            #1;
            chk("fair_gnt", 32'(dbg_if.dbg_gnt), 32'(c == 16));
            chk("fair_stall", 32'(cpu_stall), 32'(c == 16));
            if (c == 16) chk("fair_mask", {28'd0, rf_load, rf_sr1}, {28'd0, 1'b0, 3'd7});
        end
`else
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge Clk);
            #1;
            chk("starve_gnt", 32'(dbg_if.dbg_gnt), 32'd0);
            chk("starve_stall", 32'(cpu_stall), 32'd0);
        end
`endif
        @(negedge Clk);
        idle_inputs();
        repeat (3) @(negedge Clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
